// File: rtl/adder_op_sequencer.sv
// adder_op_sequencer: byte-serial controller for the 8-bit adder slice.
// Loads operands A then B LSB-first over a valid/ready input stream.
// It then drives the external adder one byte per cycle, chaining the
// carry from byte to byte. The result goes out LSB-first on a
// valid/ready output stream, followed by a status byte.
// Optional feature macro: ADDSEQ_SUB_EN adds the op_sub port, which
// selects subtraction (A - B, with the borrow reported in the status byte).
//
// Handshake: a byte moves on a rising edge where valid and ready are both
// high. The producer holds valid and data until that edge. This block
// holds out_valid and out_data stable while out_ready is low.
module adder_op_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       busy
`ifdef ADDSEQ_SUB_EN
    ,
    input  logic       op_sub
`endif
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int W  = 8 * NBYTES;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_ADD    = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic           carry_q, carry_d;
    logic           sub_w;
    logic           in_fire, out_fire, cnt_last, cnt_end;
    logic [7:0]     a_byte, b_byte, r_byte, status_byte;

`ifdef ADDSEQ_SUB_EN
    logic           sub_q, sub_d;
    assign sub_w = sub_q;
`else
    assign sub_w = 1'b0;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign cnt_last = (cnt_q == CW'(NBYTES - 1));
    assign cnt_end  = (cnt_q == CW'(NBYTES));
    // The borrow is the inverted carry when subtracting; bit1 flags subtraction.
    assign status_byte = {6'b0, sub_w, carry_q ^ sub_w};

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Next state: each phase ends on its last byte or cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD_A: if (in_fire && cnt_last)  state_d = ST_LOAD_B;
            ST_LOAD_B: if (in_fire && cnt_last)  state_d = ST_ADD;
            ST_ADD:    if (cnt_last)             state_d = ST_OUT;
            ST_OUT:    if (out_fire && cnt_end)  state_d = ST_LOAD_A;
            default:                             state_d = ST_LOAD_A;
        endcase
    end

    // Select the operand and result bytes addressed by the byte counter.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        r_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
                r_byte = r_q[8*i +: 8];
            end
        end
    end

    // Datapath updates: capture operands, store sums, chain carry, step counter.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
`ifdef ADDSEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_LOAD_A: begin
                if (in_fire) begin
                    for (int i = 0; i < NBYTES; i++)
                        if (cnt_q == CW'(i)) a_d[8*i +: 8] = in_data;
`ifdef ADDSEQ_SUB_EN
                    if (cnt_q == '0) sub_d = op_sub;
`endif
                    cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
                end
            end
            ST_LOAD_B: begin
                if (in_fire) begin
                    for (int i = 0; i < NBYTES; i++)
                        if (cnt_q == CW'(i)) b_d[8*i +: 8] = in_data;
                    // Subtraction is A + ~B + 1, so the chain starts with carry set.
                    if (cnt_last) carry_d = sub_w;
                    cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
                end
            end
            ST_ADD: begin
                for (int i = 0; i < NBYTES; i++)
                    if (cnt_q == CW'(i)) r_d[8*i +: 8] = add_sum;
                carry_d = add_cout;
                cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
            end
            ST_OUT: begin
                if (out_fire) cnt_d = cnt_end ? '0 : cnt_q + CW'(1);
            end
            default: cnt_d = '0;
        endcase
    end

    // Outputs: stream handshakes, result/status byte, and adder operands.
    // in_ready is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = !rst && ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B));
        out_valid = (state_q == ST_OUT);
        out_data  = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        busy      = !((state_q == ST_LOAD_A) && (cnt_q == '0));
        if (state_q == ST_OUT)
            out_data = cnt_end ? status_byte : r_byte;
        if (state_q == ST_ADD) begin
            add_a   = a_byte;
            add_b   = b_byte ^ {8{sub_w}};
            add_cin = carry_q;
        end
    end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Testbench for adder_op_sequencer with NBYTES=2. It models the external
// adder slice and predicts every output from plain integer arithmetic.
module tb_adder_op_sequencer;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data, add_a, add_b, add_sum;
    logic       add_cin, add_cout, busy;
`ifdef ADDSEQ_SUB_EN
    logic       op_sub;
`endif

    int tests_run = 0;
    int failed    = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset / external adder ----------------
    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    adder_op_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
`ifdef ADDSEQ_SUB_EN
        , .op_sub(op_sub)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers (entered and left at a falling edge) ----------------
    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drains exp_q from the output stream. With stall set, the first byte is
    // held for 5 cycles and out_ready then toggles every cycle.
    task automatic recv_all(input bit stall);
        int  n = 0;
        logic rdy;
        if (stall) begin
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, exp_q[0]);
                @(negedge clk);
            end
        end
        rdy = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            out_ready = rdy;
            if (out_valid && out_ready) begin
                check("out_byte", out_data, exp_q.pop_front());
            end
            @(negedge clk);
            if (stall) rdy = ~rdy;
            n++;
        end
        if (exp_q.size() > 0) begin
            check("out_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        out_ready = 1'b0;
        check("done_out_valid", out_valid, 1'b0);
        check("done_in_ready", in_ready, 1'b1);
        check("done_busy", busy, 1'b0);
    endtask

    // One complete operation; expectations come from integer arithmetic.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sub, input bit junk, input bit stall);
        logic [W-1:0] res;
        logic [7:0]   exp_b;
        longint       mask, al, bl;
        bit           cin, flag;
        for (int i = 0; i < NB; i++) begin
`ifdef ADDSEQ_SUB_EN
            op_sub = (i == 0) ? sub : ~sub;
`endif
            send_byte(a[8*i +: 8]);
        end
        for (int i = 0; i < NB; i++) send_byte(b[8*i +: 8]);
        // One falling edge past the edge that took the last B byte: first ADD cycle.
        in_valid = junk;
        for (int i = 0; i < NB; i++) begin
            in_data = 8'($urandom);
            mask  = (longint'(1) << (8 * i)) - 1;
            al    = longint'(a) & mask;
            bl    = longint'(b) & mask;
            cin   = sub ? (al >= bl) : ((al + bl) > mask);
            exp_b = sub ? ~b[8*i +: 8] : b[8*i +: 8];
            check("add_in_ready", in_ready, 1'b0);
            check("add_out_valid", out_valid, 1'b0);
            check("add_busy", busy, 1'b1);
            check("add_a", add_a, a[8*i +: 8]);
            check("add_b", add_b, exp_b);
            check("add_cin", add_cin, cin);
            @(negedge clk);
        end
        // Counting the accepting edge, NB+1 edges have passed: result must be valid.
        check("latency_out_valid", out_valid, 1'b1);
        check("out_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        check("idle_add_a", add_a, 8'h00);
        check("idle_add_cin", add_cin, 1'b0);
        res  = sub ? (a - b) : (a + b);
        flag = sub ? (a < b) : ((longint'(a) + longint'(b)) >= (longint'(1) << W));
        for (int i = 0; i < NB; i++) exp_q.push_back(res[8*i +: 8]);
        exp_q.push_back({6'b0, sub, flag});
        recv_all(stall);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] ra, rb;
        bit rs;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef ADDSEQ_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_add_a", add_a, 8'h00);
        check("rst_add_b", add_b, 8'h00);
        check("rst_add_cin", add_cin, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);

        // A=0x1234, B=0x0FCD -> 01 22 00
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
        // A=0xFFFF, B=0x0001 -> 00 00 01, carry ripples into byte 1
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        // Output back-pressure: stall first byte, then toggle out_ready
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1);

        // Reset after A and one B byte: everything partial is discarded
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("midload_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_busy", busy, 1'b0);
        check("postrst_in_ready", in_ready, 1'b1);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Junk held on in_valid during ADD and first OUT cycle
        run_op(16'hA5C3, 16'h7E19, 1'b0, 1'b1, 1'b0);

`ifdef ADDSEQ_SUB_EN
        // 0x0005 - 0x0007 -> FE FF 03
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        run_op(16'h0007, 16'h0007, 1'b1, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 16; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k == 0) rb = ~ra;
            if (k == 1) rb = 16'hFFFF;
`ifdef ADDSEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
